// File: rtl/nes_pkg.sv
// Shared NES controller definitions: button bit positions and pad scanner states.
package nes_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_CLK_HI = 3'd4,
    ST_COMMIT = 3'd5
  } pad_scan_state_t;

endpackage

// File: rtl/joypad_scanner.sv
// Periodic scanner for two physical NES pads; commits both bytes atomically.
module joypad_scanner
  import nes_pkg::*;
#(
  parameter int unsigned SCAN_HALF   = 64,
  parameter int unsigned SCAN_PERIOD = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       scan_done,
  output logic [7:0] pad_byte0,
  output logic [7:0] pad_byte1
);

  localparam int unsigned PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned TMR_W = $clog2(2 * SCAN_HALF);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SCAN_PERIOD - 1);
  localparam logic [TMR_W-1:0] LATCH_LAST = TMR_W'(2 * SCAN_HALF - 1);
  localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(SCAN_HALF - 1);

  pad_scan_state_t   state;
  pad_scan_state_t   state_nx;
  logic [PER_W-1:0]  per_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [2:0]        bit_idx;
  logic [1:0]        pad_meta;
  logic [1:0]        pad_sync;
  logic [7:0]        shadow0;
  logic [7:0]        shadow1;
  logic              period_end;

  assign period_end = (per_cnt == PER_LAST);

  // Free-running period counter so scan starts stay exactly one period apart.
  always_ff @(posedge clk) begin
    if (rst)             per_cnt <= '0;
    else if (period_end) per_cnt <= '0;
    else                 per_cnt <= per_cnt + PER_W'(1);
  end

  // Scanner state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (period_end) state_nx = ST_LATCH;
      ST_LATCH:  if (tmr == LATCH_LAST) state_nx = ST_SAMPLE;
      ST_SAMPLE: state_nx = ST_CLK_LO;
      ST_CLK_LO: if (tmr == HALF_LAST) state_nx = ST_CLK_HI;
      ST_CLK_HI: if (tmr == HALF_LAST) state_nx = (bit_idx == 3'd7) ? ST_COMMIT : ST_SAMPLE;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Phase timer, synchroniser, shadow capture, commit and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr       <= '0;
      bit_idx   <= '0;
      pad_meta  <= 2'b11;
      pad_sync  <= 2'b11;
      shadow0   <= '0;
      shadow1   <= '0;
      pad_byte0 <= '0;
      pad_byte1 <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      scan_done <= 1'b0;
    end else begin
      tmr       <= (state_nx != state) ? '0 : tmr + TMR_W'(1);
      pad_meta  <= pad_data;
      pad_sync  <= pad_meta;
      pad_latch <= (state_nx == ST_LATCH);
      pad_clk   <= (state_nx != ST_CLK_LO);
      scan_done <= (state == ST_COMMIT);
      if (state == ST_LATCH) bit_idx <= '0;
      if (state == ST_SAMPLE) begin
        shadow0[bit_idx] <= ~pad_sync[0];
        shadow1[bit_idx] <= ~pad_sync[1];
      end
      if (state == ST_CLK_HI && state_nx == ST_SAMPLE) bit_idx <= bit_idx + 3'd1;
      if (state == ST_COMMIT) begin
        pad_byte0 <= shadow0;
        pad_byte1 <= shadow1;
      end
    end
  end

endmodule

// File: rtl/joypad_ctrl.sv
// NES controller back-end: two emulated serial pad shift registers fed by
// scanned physical pads merged with host buttons.
module joypad_ctrl
  import nes_pkg::*;
#(
  parameter int unsigned SCAN_HALF   = 64,
  parameter int unsigned SCAN_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ctrl_strobe,
  input  logic [1:0]  ctrl_out,
  output logic [1:0]  ctrl_data,
  input  logic [15:0] ext_btn,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic [1:0]  pad_data,
  output logic        scan_done
);

  logic [7:0] pad_byte0;
  logic [7:0] pad_byte1;
  logic [7:0] btn_eff0;
  logic [7:0] btn_eff1;
  logic [7:0] sr0;
  logic [7:0] sr1;
  logic [1:0] out_q;
  logic [1:0] out_rise;
  logic       strobe_unused;

  assign strobe_unused = ^ctrl_strobe[2:1];

  joypad_scanner #(
    .SCAN_HALF   (SCAN_HALF),
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .scan_done (scan_done),
    .pad_byte0 (pad_byte0),
    .pad_byte1 (pad_byte1)
  );

  assign btn_eff0  = pad_byte0 | ext_btn[7:0];
  assign btn_eff1  = pad_byte1 | ext_btn[15:8];
  assign out_rise  = ctrl_out & ~out_q;
  assign ctrl_data = {sr1[BTN_A], sr0[BTN_A]};

  // Serial shift registers: strobe reloads, one shift per read rising edge, 1s fill in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr0   <= '0;
      sr1   <= '0;
      out_q <= '0;
    end else begin
      out_q <= ctrl_out;
      if (ctrl_strobe[0]) begin
        sr0 <= btn_eff0;
        sr1 <= btn_eff1;
      end else begin
        if (out_rise[0]) sr0 <= {1'b1, sr0[7:1]};
        if (out_rise[1]) sr1 <= {1'b1, sr1[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_joypad_ctrl.sv
// Directed bench for joypad_ctrl with a behavioural two-pad 4021 model.
module tb_joypad_ctrl;

  localparam int unsigned SCAN_HALF   = 4;
  localparam int unsigned SCAN_PERIOD = 200;
  localparam int unsigned SCAN_LEN    = 18 * SCAN_HALF + 9;

  logic        clk;
  logic        rst;
  logic [2:0]  ctrl_strobe;
  logic [1:0]  ctrl_out;
  logic [1:0]  ctrl_data;
  logic [15:0] ext_btn;
  logic        pad_latch;
  logic        pad_clk;
  logic [1:0]  pad_data;
  logic        scan_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] pad_btn0 = 8'h00;
  logic [7:0] pad_btn1 = 8'h00;
  logic [7:0] sh0 = 8'h00;
  logic [7:0] sh1 = 8'h00;
  logic       clk_prev = 1'b1;

  joypad_ctrl #(
    .SCAN_HALF   (SCAN_HALF),
    .SCAN_PERIOD (SCAN_PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_strobe (ctrl_strobe),
    .ctrl_out    (ctrl_out),
    .ctrl_data   (ctrl_data),
    .ext_btn     (ext_btn),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .pad_data    (pad_data),
    .scan_done   (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: parallel load while latched, shift on pad_clk rising, active-low data.
  always @(posedge clk) begin
    clk_prev <= pad_clk;
    if (pad_latch) begin
      sh0 <= pad_btn0;
      sh1 <= pad_btn1;
    end else if (pad_clk && !clk_prev) begin
      sh0 <= {1'b0, sh0[7:1]};
      sh1 <= {1'b0, sh1[7:1]};
    end
  end
  assign pad_data = ~{sh1[0], sh0[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe_load();
    @(negedge clk) ctrl_strobe = 3'b001;
    @(negedge clk);
    @(negedge clk) ctrl_strobe = 3'b000;
  endtask

  task automatic read_bytes(output logic [7:0] b0, output logic [7:0] b1);
    strobe_load();
    for (int i = 0; i < 8; i++) begin
      b0[i] = ctrl_data[0];
      b1[i] = ctrl_data[1];
      ctrl_out = 2'b11;
      @(negedge clk) ctrl_out = 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic wait_latch_rise(output int at, output logic found);
    logic prev;
    found = 1'b0;
    at = 0;
    prev = pad_latch;
    for (int n = 0; n < 3 * SCAN_PERIOD; n++) begin
      @(posedge clk); #1;
      if (!prev && pad_latch) begin
        found = 1'b1;
        at = cyc;
        break;
      end
      prev = pad_latch;
    end
  endtask

  task automatic wait_scan_done(output int at, output logic found);
    found = 1'b0;
    at = 0;
    for (int n = 0; n < 3 * SCAN_PERIOD; n++) begin
      @(posedge clk); #1;
      if (scan_done) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_clk_low(output logic found);
    found = 1'b0;
    for (int n = 0; n < 3 * SCAN_PERIOD; n++) begin
      @(posedge clk); #1;
      if (!pad_clk) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [9:0] exp_seq;
    logic [7:0] b0, b1;
    logic       found;
    int         start1, start2, t_done, latch_len, pulses, lo, min_w, max_w, n;

    rst = 1'b1;
    ctrl_strobe = 3'b000;
    ctrl_out = 2'b00;
    ext_btn = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl_data", 32'(ctrl_data), 32'h0);
    check("rst_pad_latch", 32'(pad_latch), 32'h0);
    check("rst_pad_clk", 32'(pad_clk), 32'h1);
    check("rst_scan_done", 32'(scan_done), 32'h0);
    @(negedge clk) rst = 1'b0;

    // Strobe/read: 0x81 on port0 reads A, six zeros, Right, then 1s.
    ext_btn = 16'h0081;
    exp_seq = 10'b1110000001;
    strobe_load();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("read_bit%0d", i), 32'(ctrl_data[0]), 32'(exp_seq[i]));
      ctrl_out = 2'b01;
      @(negedge clk) ctrl_out = 2'b00;
      @(negedge clk);
    end

    // Stretched read on port1 shifts once; port0 untouched.
    ext_btn = 16'h0201;
    strobe_load();
    check("stretch_pre", 32'(ctrl_data), 32'h1);
    ctrl_out = 2'b10;
    @(negedge clk);
    check("stretch_mid", 32'(ctrl_data), 32'h3);
    @(negedge clk);
    @(negedge clk) ctrl_out = 2'b00;
    check("stretch_end", 32'(ctrl_data), 32'h3);
    @(negedge clk) ctrl_out = 2'b10;
    @(negedge clk) ctrl_out = 2'b00;
    check("stretch_next", 32'(ctrl_data), 32'h1);

    // Strobe dominance: data follows btn_eff bit 0 while strobe held.
    ext_btn = 16'h0001;
    ctrl_strobe = 3'b001;
    ctrl_out = 2'b11;
    @(negedge clk) ctrl_out = 2'b00;
    check("dom_0", 32'(ctrl_data), 32'h1);
    @(negedge clk) ctrl_out = 2'b11;
    check("dom_1", 32'(ctrl_data), 32'h1);
    @(negedge clk) ext_btn = 16'h0100;
    check("dom_2", 32'(ctrl_data), 32'h1);
    @(negedge clk) ctrl_out = 2'b00;
    check("dom_3", 32'(ctrl_data), 32'h2);
    @(negedge clk) ctrl_strobe = 3'b000;
    @(negedge clk);
    check("dom_hold", 32'(ctrl_data), 32'h2);
    ext_btn = 16'h0000;

    // Pad scan: A on pad0, Start on pad1.
    pad_btn0 = 8'h01;
    pad_btn1 = 8'h08;
    wait_latch_rise(start1, found);
    check("scan1_start", 32'(found), 32'h1);
    latch_len = 0;
    while (pad_latch && latch_len < 100) begin
      latch_len++;
      @(posedge clk); #1;
    end
    check("latch_len", 32'(latch_len), 32'(2 * SCAN_HALF));
    pulses = 0; lo = 0; min_w = 1000; max_w = 0; found = 1'b0; t_done = 0;
    for (int k = 0; k < 4 * SCAN_LEN; k++) begin
      if (!pad_clk) lo++;
      else if (lo > 0) begin
        pulses++;
        if (lo < min_w) min_w = lo;
        if (lo > max_w) max_w = lo;
        lo = 0;
      end
      if (scan_done) begin
        found = 1'b1;
        t_done = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check("scan1_done", 32'(found), 32'h1);
    check("clk_pulses", 32'(pulses), 32'h8);
    check("clk_min_w", 32'(min_w), 32'(SCAN_HALF));
    check("clk_max_w", 32'(max_w), 32'(SCAN_HALF));
    check("done_latency", 32'(t_done - start1), 32'(SCAN_LEN));
    @(posedge clk); #1;
    check("done_width", 32'(scan_done), 32'h0);
    @(negedge clk);
    read_bytes(b0, b1);
    check("pad_byte0", 32'(b0), 32'h01);
    check("pad_byte1", 32'(b1), 32'h08);

    // Scan 2 with a pad change: mid-scan strobe still sees the committed bytes.
    wait_latch_rise(start2, found);
    check("scan2_start", 32'(found), 32'h1);
    check("scan_period", 32'(start2 - start1), 32'(SCAN_PERIOD));
    pad_btn0 = 8'h02;
    wait_clk_low(found);
    check("scan2_clk_low", 32'(found), 32'h1);
    @(negedge clk);
    read_bytes(b0, b1);
    check("mid_scan_byte0", 32'(b0), 32'h01);
    check("mid_scan_byte1", 32'(b1), 32'h08);
    wait_scan_done(t_done, found);
    check("scan2_done", 32'(found), 32'h1);
    @(negedge clk);
    read_bytes(b0, b1);
    check("post_scan_byte0", 32'(b0), 32'h02);
    check("post_scan_byte1", 32'(b1), 32'h08);

    // Reset in CLK_LO of scan 3.
    wait_clk_low(found);
    check("scan3_clk_low", 32'(found), 32'h1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_pad_clk", 32'(pad_clk), 32'h1);
    check("mid_rst_pad_latch", 32'(pad_latch), 32'h0);
    check("mid_rst_ctrl_data", 32'(ctrl_data), 32'h0);
    @(negedge clk) rst = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 3 * SCAN_PERIOD) begin
      @(posedge clk); #1;
      n++;
      if (scan_done) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_first_done_seen", 32'(found), 32'h1);
    check("rst_first_done_time", 32'(n), 32'(SCAN_PERIOD + SCAN_LEN));
    @(negedge clk);
    read_bytes(b0, b1);
    check("rst_rescan_byte0", 32'(b0), 32'h02);
    check("rst_rescan_byte1", 32'(b1), 32'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
